// File: rtl/lc_mem_arbiter_pkg.sv
// Shared layer-memory definitions: MEM port widths, arbiter FSM encodings and
// the default watchdog limit used by lc_mem_arbiter.
package lc_mem_arbiter_pkg;

   localparam int LC_MEM_ADDR_WIDTH  = 30;
   localparam int LC_MEM_DATA_WIDTH  = 32;
   localparam int LC_MEM_ARB_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_REL  = 2'd3
   } arb_state_t;

   // Returns the winning requester index; only meaningful when req != 0.
   function automatic logic pick_winner(input logic [1:0] req, input logic favor);
      if (req == 2'b11) return favor;
      return req[1];
   endfunction

endpackage

// File: rtl/lc_mem_arbiter_watchdog.sv
// Loadable down-counter with an expiry flag; bounds how long the arbiter waits
// for the memory acknowledge.
module lc_mem_arb_watchdog #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          expired
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/lc_mem_arbiter.sv
// Round-robin arbiter sharing one layer memory port between the layer
// controller (requester 0) and the CPU (requester 1). Watchdog: MEM_ARB_TIMEOUT_EN.
module lc_mem_arbiter
   import lc_mem_arbiter_pkg::*;
#(
   parameter int AW             = LC_MEM_ADDR_WIDTH,
   parameter int DW             = LC_MEM_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = LC_MEM_ARB_TIMEOUT
) (
   input  logic            CLK,
   input  logic            RESETn,
   input  logic [1:0]      REQ_IN,
   input  logic [1:0]      WRITE_IN,
   input  logic [2*AW-1:0] ADDR_IN,
   input  logic [2*DW-1:0] DATA_IN,
   output logic [1:0]      ACK_OUT,
   output logic [DW-1:0]   RD_DATA_OUT,
   output logic            ERR_OUT,
   output logic [1:0]      GRANT_OUT,
   output logic            MEM_REQ_OUT,
   output logic            MEM_WRITE,
   output logic [AW-1:0]   MEM_ADDR_OUT,
   output logic [DW-1:0]   MEM_DATA_OUT,
   input  logic            MEM_ACK_IN,
   input  logic [DW-1:0]   MEM_DATA_IN
);

   arb_state_t    state, state_nx;
   logic [1:0]    grant_r, grant_nx;
   logic [1:0]    ack_r, ack_nx;
   logic          err_r, err_nx;
   logic [DW-1:0] rd_r, rd_nx;
   logic          mem_req_r, mem_req_nx;
   logic          mem_write_r, mem_write_nx;
   logic [AW-1:0] mem_addr_r, mem_addr_nx;
   logic [DW-1:0] mem_data_r, mem_data_nx;
   logic          favor_r, favor_nx;

   logic          win;
   logic          owner;
   logic          wd_load;
   logic          wd_expired;

   assign win   = pick_winner(REQ_IN, favor_r);
   assign owner = grant_r[1];

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int T_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
   localparam int CW    = $clog2(T_EFF + 1);
   // Loaded with T-1 at grant so expiry lands on the T-th cycle spent in REQ.
   localparam logic [CW-1:0] WD_LOAD = CW'(T_EFF - 1);

   lc_mem_arb_watchdog #(
      .CW(CW)
   ) u_watchdog (
      .clk     (CLK),
      .rst_n   (RESETn),
      .load    (wd_load),
      .load_val(WD_LOAD),
      .en      (state == ST_REQ),
      .expired (wd_expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^{TIMEOUT_CYCLES, wd_load};
   assign wd_expired     = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state       <= ST_IDLE;
         grant_r     <= '0;
         ack_r       <= '0;
         err_r       <= 1'b0;
         rd_r        <= '0;
         mem_req_r   <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_data_r  <= '0;
         favor_r     <= 1'b0;
      end else begin
         state       <= state_nx;
         grant_r     <= grant_nx;
         ack_r       <= ack_nx;
         err_r       <= err_nx;
         rd_r        <= rd_nx;
         mem_req_r   <= mem_req_nx;
         mem_write_r <= mem_write_nx;
         mem_addr_r  <= mem_addr_nx;
         mem_data_r  <= mem_data_nx;
         favor_r     <= favor_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      grant_nx     = grant_r;
      ack_nx       = ack_r;
      err_nx       = err_r;
      rd_nx        = rd_r;
      mem_req_nx   = mem_req_r;
      mem_write_nx = mem_write_r;
      mem_addr_nx  = mem_addr_r;
      mem_data_nx  = mem_data_r;
      favor_nx     = favor_r;
      wd_load      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (|REQ_IN) begin
               grant_nx     = win ? 2'b10 : 2'b01;
               mem_req_nx   = 1'b1;
               mem_write_nx = WRITE_IN[win];
               mem_addr_nx  = win ? ADDR_IN[2*AW-1:AW] : ADDR_IN[AW-1:0];
               mem_data_nx  = win ? DATA_IN[2*DW-1:DW] : DATA_IN[DW-1:0];
               wd_load      = 1'b1;
               state_nx     = ST_REQ;
            end
         end
         ST_REQ: begin
            // A real acknowledge wins over a watchdog expiry in the same cycle.
            if (MEM_ACK_IN) begin
               ack_nx = grant_r;
               if (!mem_write_r)
                  rd_nx = MEM_DATA_IN;
               state_nx = ST_ACK;
            end else if (wd_expired) begin
               mem_req_nx = 1'b0;
               ack_nx     = grant_r;
               err_nx     = 1'b1;
               state_nx   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!REQ_IN[owner]) begin
               ack_nx     = '0;
               err_nx     = 1'b0;
               mem_req_nx = 1'b0;
               state_nx   = ST_REL;
            end
         end
         ST_REL: begin
            if (!MEM_ACK_IN) begin
               grant_nx = '0;
               favor_nx = ~owner;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign ACK_OUT      = ack_r;
   assign RD_DATA_OUT  = rd_r;
   assign ERR_OUT      = err_r;
   assign GRANT_OUT    = grant_r;
   assign MEM_REQ_OUT  = mem_req_r;
   assign MEM_WRITE    = mem_write_r;
   assign MEM_ADDR_OUT = mem_addr_r;
   assign MEM_DATA_OUT = mem_data_r;

endmodule

// File: doc/lc_mem_arbiter.md
# lc_mem_arbiter

Two-requester arbiter that shares one layer memory port between the layer controller's MEM interface (requester 0) and the local processor (requester 1). It sits between those masters and the memory macro. It relays the four-phase MEM_REQ/MEM_ACK handshake for exactly one granted requester at a time, using round-robin priority. Read data is captured and returned with the requester's acknowledge.

## Interface
Parameters:
- AW, default `LC_MEM_ADDR_WIDTH: memory address width.
- DW, default `LC_MEM_DATA_WIDTH: memory data width.
- TIMEOUT_CYCLES, default 255: watchdog limit. Used only when the watchdog is compiled in.

Ports:
- CLK  in  1  block clock.
- RESETn  in  1  reset, synchronous, active-low; one clock.
- REQ_IN  in  2  request per requester (bit 0 = layer ctrl, bit 1 = CPU).
- WRITE_IN  in  2  1 = write, 0 = read; stable while the matching REQ_IN is high.
- ADDR_IN  in  2*AW  packed addresses; requester i at [AW*(i+1)-1:AW*i].
- DATA_IN  in  2*DW  packed write data, same packing.
- ACK_OUT  out  2  per-requester acknowledge.
- RD_DATA_OUT  out  DW  read data; valid while any ACK_OUT bit is high.
- ERR_OUT  out  1  transaction aborted by timeout; valid with ACK_OUT.
- GRANT_OUT  out  2  one-hot current owner; 0 when idle.
- MEM_REQ_OUT  out  1  memory request.
- MEM_WRITE  out  1  memory write enable.
- MEM_ADDR_OUT  out  AW  memory address.
- MEM_DATA_OUT  out  DW  memory write data.
- MEM_ACK_IN  in  1  memory acknowledge.
- MEM_DATA_IN  in  DW  memory read data; valid while MEM_ACK_IN is high.

## Operation
- All outputs are registered. Reset value of every output is 0. Round-robin pointer resets to 0, so requester 0 wins the first tie.
- FSM states:
  - IDLE: if any REQ_IN is high, pick the winner, latch WRITE/ADDR/DATA into the MEM_* outputs, set GRANT_OUT and MEM_REQ_OUT, go to REQ.
  - REQ: wait for MEM_ACK_IN. On MEM_ACK_IN=1, capture MEM_DATA_IN into RD_DATA_OUT (reads only; writes leave it unchanged), set ACK_OUT[grant], go to ACK.
  - ACK: wait for REQ_IN[grant]=0. Then clear ACK_OUT, clear MEM_REQ_OUT, go to REL.
  - REL: wait for MEM_ACK_IN=0. Then clear GRANT_OUT, flip the pointer to favour the other requester, go to IDLE.
- Arbitration happens only in IDLE. Requests that arrive during REQ, ACK or REL wait. The owner cannot be pre-empted.
- Both REQ_IN bits high in IDLE: the requester not granted last wins. Back-to-back traffic from both requesters alternates strictly.
- A requester dropping REQ_IN before its ACK_OUT is a protocol violation. The FSM keeps waiting in REQ and completes normally.
- MEM_ADDR_OUT, MEM_DATA_OUT and MEM_WRITE hold their values from grant until the next grant.
- Non-granted ACK_OUT bits are always 0.

## Timing
- REQ_IN rises in cycle N (FSM in IDLE) → MEM_REQ_OUT and GRANT_OUT high at N+1.
- MEM_ACK_IN high in cycle M → ACK_OUT and RD_DATA_OUT at M+1.
- REQ_IN low in cycle K → ACK_OUT and MEM_REQ_OUT low at K+1.
- MEM_ACK_IN low in cycle L → IDLE at L+1. A pending request is granted at L+2.
- Minimum transaction with a 0-wait memory: 5 cycles from request to idle.
- RESETn low during any state returns the FSM to IDLE next cycle with all outputs 0. The memory sees MEM_REQ_OUT drop and must tolerate the aborted handshake.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in REQ.
  - When the count reaches TIMEOUT_CYCLES without MEM_ACK_IN, the FSM clears MEM_REQ_OUT and sets ACK_OUT[grant] and ERR_OUT=1 (RD_DATA_OUT unchanged), then goes to ACK.
  - ERR_OUT clears together with ACK_OUT.
  - The counter resets on every entry to REQ.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; REQ waits indefinitely.
  - ERR_OUT is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- The FSM state encodings (IDLE/REQ/ACK/REL) and the default TIMEOUT_CYCLES belong in the shared mbus definitions header/package, next to the `LC_MEM_*` widths.
- One sub-module: lc_mem_arb_watchdog, a loadable down-counter with an expiry flag. It is instantiated only under MEM_ARB_TIMEOUT_EN.
- Winner selection, the request mux and the handshake FSM stay in the top level.

## Test plan
- Single read: REQ_IN=01, ADDR_IN[0]=0x10, memory returns 0xDEADBEEF after 3 cycles → MEM_ADDR_OUT=0x10 and MEM_WRITE=0; ACK_OUT=01 with RD_DATA_OUT=0xDEADBEEF; GRANT_OUT=00 after release.
- Single write from CPU: REQ_IN=10, WRITE_IN=10, DATA_IN[1]=0x12345678 → MEM_WRITE=1 and MEM_DATA_OUT=0x12345678; ACK_OUT=10; RD_DATA_OUT unchanged.
- Simultaneous requests from reset: REQ_IN=11 held through 4 transactions → grant order 0,1,0,1; never two ACK_OUT bits high together.
- Late arrival: requester 1 raises REQ while requester 0 is in REQ state → requester 1 is granted only after requester 0 reaches IDLE, exactly 2 cycles after MEM_ACK_IN falls.
- Reset mid-transaction: RESETn=0 for one cycle in ACK state → next cycle all outputs 0 and the FSM is in IDLE; a subsequent REQ_IN=01 is granted (pointer back at 0).
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never acknowledges → ACK_OUT=01 and ERR_OUT=1 8 cycles after MEM_REQ_OUT rose; without the macro, MEM_REQ_OUT stays high for 1000 cycles and ERR_OUT=0.
